// File: rtl/decoder_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module : decoder_rr_arbiter_pkg
//  Desc   : Shared types, sizes and round-robin pick function for the arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
package decoder_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // First set request scanning ptr, ptr+1, ... with 3-bit wraparound.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_rr_arbiter_grant_decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module : grant_decoder_3to8
//  Desc   : Gate-level 3-to-8 decoder with enable; drives the one-hot grant.
//  Rev    : 1.0  initial release
// ============================================================================
module grant_decoder_3to8 (
  input  logic [2:0] i_a,
  input  logic       i_en,
  output logic [7:0] o_y
);

  logic [2:0] w_an;

  assign w_an = ~i_a;

  and u_y0 (o_y[0], i_en, w_an[2], w_an[1], w_an[0]);
  and u_y1 (o_y[1], i_en, w_an[2], w_an[1], i_a[0]);
  and u_y2 (o_y[2], i_en, w_an[2], i_a[1],  w_an[0]);
  and u_y3 (o_y[3], i_en, w_an[2], i_a[1],  i_a[0]);
  and u_y4 (o_y[4], i_en, i_a[2],  w_an[1], w_an[0]);
  and u_y5 (o_y[5], i_en, i_a[2],  w_an[1], i_a[0]);
  and u_y6 (o_y[6], i_en, i_a[2],  i_a[1],  w_an[0]);
  and u_y7 (o_y[7], i_en, i_a[2],  i_a[1],  i_a[0]);

endmodule
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : decoder_rr_arbiter
//  Desc   : 8-way round-robin arbiter with hold timeout, driving a 3-to-8 decoder.
//  Rev    : 1.0  initial release
// ============================================================================
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_arb_en,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;
  logic             r_timeout;

  logic             w_hold_done;
  logic             w_release;
  logic [IDX_W-1:0] w_pick;

  assign w_hold_done = (MAX_HOLD != 0) && (r_cnt == C_HOLD_LAST);
  assign w_release   = ~i_req[r_idx];
  assign w_pick      = rr_pick(i_req, r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_arb_en && (|i_req)) begin
            r_state <= GRANT;
            r_idx   <= w_pick;
            r_vld   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          // Timeout wins over a same-cycle release so the pulse is never lost.
          if (w_hold_done || w_release || !i_arb_en) begin
            r_state   <= GAP;
            r_vld     <= 1'b0;
            r_ptr     <= r_idx + 1'b1;
            r_timeout <= w_hold_done;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  grant_decoder_3to8 u_dec (
    .i_a  (r_idx),
    .i_en (r_vld),
    .o_y  (o_gnt)
  );

  assign o_gnt_idx = r_idx;
  assign o_gnt_vld = r_vld;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_decoder_rr_arbiter
//  Desc   : Scoreboard bench for decoder_rr_arbiter (MAX_HOLD=4 and MAX_HOLD=0).
//  Rev    : 1.0  initial release
// ============================================================================
module tb_decoder_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic       to;
    logic [2:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arb_en;
  logic [7:0] req;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b, to_a, to_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_arb_en(arb_en), .i_req(req),
    .o_gnt(gnt_a), .o_gnt_idx(idx_a), .o_gnt_vld(vld_a), .o_timeout(to_a)
  );

  decoder_rr_arbiter #(.MAX_HOLD(0), .CNT_W(5)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .i_arb_en(arb_en), .i_req(req),
    .o_gnt(gnt_b), .o_gnt_idx(idx_b), .o_gnt_vld(vld_b), .o_timeout(to_b)
  );

  task automatic apply_reset();
    rst_n  = 1'b0;
    req    = 8'h00;
    arb_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; req = 8'h00; arb_en = 1'b1;
    #2;
    n_cmp++;
    if (gnt_a !== 8'h00 || vld_a !== 1'b0 || idx_a !== 3'd0 || to_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%h vld=%b idx=%0d to=%b, expected 00 0 0 0", gnt_a, vld_a, idx_a, to_a);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req = 8'h00;
      sb.push_back(exp_t'{8'h00, 1'b0, 3'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_a !== e.gnt || vld_a !== 1'b0 || to_a !== e.to) begin
        n_bad++;
        $display("FAIL idle_no_req c=%0d: gnt=%h vld=%b to=%b, expected gnt=%h vld=0 to=%b", c, gnt_a, vld_a, to_a, e.gnt, e.to);
      end
    end
    req = 8'h01;
    sb.push_back(exp_t'{8'h01, 1'b0, 3'd0});
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (gnt_a !== e.gnt || gnt_b !== e.gnt) begin
      n_bad++;
      $display("FAIL pre_reset_grant: gnt_a=%h gnt_b=%h, expected %h", gnt_a, gnt_b, e.gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt_a !== 8'h00 || gnt_b !== 8'h00 || vld_a !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_mid_grant: gnt_a=%h gnt_b=%h vld=%b, expected 00 00 0", gnt_a, gnt_b, vld_a);
    end
    @(posedge clk); #1 rst_n = 1'b1; req = 8'h00;
  endtask

  task automatic test_single();
    exp_t e;
    logic [7:0] stim [6] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03};
    logic [7:0] expg [6] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      req = stim[c];
      sb.push_back(exp_t'{expg[c], 1'b0, (c == 5) ? 3'd1 : 3'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_a !== e.gnt || to_a !== e.to || (e.gnt != 8'h00 && idx_a !== e.idx)) begin
        n_bad++;
        $display("FAIL single_release c=%0d: gnt=%h to=%b idx=%0d, expected gnt=%h to=%b idx=%0d", c, gnt_a, to_a, idx_a, e.gnt, e.to, e.idx);
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    int   c;
    apply_reset();
    req = 8'hFF;
    c = 0;
    for (int g = 0; g < 9; g++) begin
      for (int p = 0; p < 6; p++) begin
        sb.push_back(exp_t'{(p < 4) ? (8'h01 << (g % 8)) : 8'h00, (p == 4), 3'(g % 8)});
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (gnt_a !== e.gnt || to_a !== e.to || (e.gnt != 8'h00 && idx_a !== e.idx)) begin
          n_bad++;
          $display("FAIL rotation c=%0d: gnt=%h to=%b idx=%0d, expected gnt=%h to=%b idx=%0d", c, gnt_a, to_a, idx_a, e.gnt, e.to, e.idx);
        end
        c++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [7:0] stim [10] = '{8'h04, 8'h00, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    logic [7:0] expg [10] = '{8'h04, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h04};
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      req = stim[c];
      sb.push_back(exp_t'{expg[c], (c == 7), 3'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_a !== e.gnt || to_a !== e.to) begin
        n_bad++;
        $display("FAIL ptr_wrap c=%0d: gnt=%h to=%b, expected gnt=%h to=%b", c, gnt_a, to_a, e.gnt, e.to);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [7:0] expg [9] = '{8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      req    = (c < 3) ? 8'h20 : 8'hFF;
      arb_en = (c < 2 || c == 8);
      sb.push_back(exp_t'{expg[c], 1'b0, 3'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_a !== e.gnt || to_a !== e.to) begin
        n_bad++;
        $display("FAIL arb_en_abort c=%0d: gnt=%h to=%b, expected gnt=%h to=%b", c, gnt_a, to_a, e.gnt, e.to);
      end
    end
    arb_en = 1'b1;
  endtask

  task automatic test_release_timeout();
    exp_t e;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      req = (c < 4) ? 8'h01 : 8'h00;
      sb.push_back(exp_t'{(c < 4) ? 8'h01 : 8'h00, (c == 4), 3'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_a !== e.gnt || to_a !== e.to) begin
        n_bad++;
        $display("FAIL release_and_timeout c=%0d: gnt=%h to=%b, expected gnt=%h to=%b", c, gnt_a, to_a, e.gnt, e.to);
      end
    end
  endtask

  task automatic test_no_timeout();
    exp_t e;
    apply_reset();
    req = 8'h10;
    for (int c = 0; c < 100; c++) begin
      sb.push_back(exp_t'{8'h10, 1'b0, 3'd4});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (gnt_b !== e.gnt || to_b !== e.to || idx_b !== e.idx) begin
        n_bad++;
        $display("FAIL no_timeout c=%0d: gnt=%h to=%b idx=%0d, expected gnt=%h to=%b idx=%0d", c, gnt_b, to_b, idx_b, e.gnt, e.to, e.idx);
      end
    end
    req = 8'h00;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 8'h00;
    arb_en = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_abort();
    test_release_timeout();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
